main_control: RTL and testbench
===============================

MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have ports opcode input 6 and funct input 6, instruction fields taken from the instruction register.
REQ-004 SHALL have port zero, input, 1, the ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, the memory access-complete handshake.
REQ-006 SHALL have these 1-bit enable outputs: pc_we, ir_we, mem_re, mem_we, rf_we.
REQ-007 SHALL have port aluop, output, 2, encoded as: 0 add, 1 sub, 2 funct-decoded.
REQ-008 SHALL have port cmpflag, output, 1, which forces the ALU compare operation.
REQ-009 SHALL have these datapath selects: alu_src_a (1), alu_src_b (2: 0 reg, 1 const 4, 2 sign-extended imm), reg_dst (1), mem_to_reg (1), pc_src (2: 0 ALU, 1 branch target, 2 jump).
REQ-010 SHALL have port state, output, 3, the current FSM state, for debug.
REQ-011 SHALL have port trap, output, 1, the illegal-instruction indicator.

Function
REQ-012 SHALL implement a Moore FSM with these state codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-013 FETCH SHALL drive mem_re=1, alu_src_a=0, alu_src_b=1, aluop=0, pc_src=0.
REQ-014 In FETCH, pc_we and ir_we SHALL be asserted only in the cycle with mem_ready=1; the FSM SHALL advance to DECODE only then and otherwise hold.
REQ-015 DECODE SHALL last one cycle with all enables 0, then go to EXEC for opcodes 000000 (R-type), 100011 (lw), 101011 (sw), 000100 (beq), 000010 (j) and 111111 (cmp).
REQ-016 EXEC for R-type SHALL drive aluop=2, then go to WB.
REQ-017 EXEC for cmp SHALL drive aluop=2 with cmpflag=1, then go to WB; cmpflag SHALL be 0 in every other state and opcode.
REQ-018 EXEC for lw/sw SHALL drive alu_src_b=2, aluop=0, then go to MEM.
REQ-019 EXEC for beq SHALL drive aluop=1, pc_src=1 and pc_we=zero, then go to FETCH.
REQ-020 EXEC for j SHALL drive pc_src=2 and pc_we=1, then go to FETCH.
REQ-021 MEM SHALL assert mem_re (lw) or mem_we (sw) and hold until mem_ready=1; lw then goes to WB and sw to FETCH.
REQ-022 mem_we SHALL be asserted for the whole MEM/sw wait.
REQ-023 WB SHALL assert rf_we for one cycle, with reg_dst=1, mem_to_reg=0 for R-type/cmp and reg_dst=0, mem_to_reg=1 for lw, then go to FETCH.
REQ-024 For R-type funct 001010 (movz), rf_we in WB SHALL equal zero.
REQ-025 Instruction latencies, with mem_ready always 1, SHALL be: R-type/cmp 4, lw 5, sw 4, beq 3, j 3 cycles.
REQ-026 Outputs not listed for a given state SHALL be 0.

Reset
REQ-027 With rst=1 at a rising edge, state SHALL become FETCH regardless of the current state, including mid-MEM wait or TRAP.
REQ-028 While rst=1, pc_we, ir_we, mem_re, mem_we, rf_we and trap SHALL be forced to 0.
REQ-029 After rst deasserts, the first fetch SHALL begin in the next cycle.

Configuration
REQ-030 With macro MAIN_CONTROL_TRAP_EN defined, an undefined opcode in DECODE SHALL go to TRAP, hold there with trap=1 and all enables 0 until reset.
REQ-031 Without MAIN_CONTROL_TRAP_EN, an undefined opcode SHALL return DECODE to FETCH as a NOP, TRAP SHALL be unreachable, and trap SHALL be tied to 0.

Structure
REQ-032 State encodings, aluop codes, opcode constants, alu_src_b and pc_src encodings SHALL live in shared package mips_ctrl_pkg, which is also used by alu_control.
REQ-033 SHALL contain one natural sub-module, main_control_decode: a combinational map from state, opcode, funct and zero to the output vector; the next-state register stays in the top module.

Verification
REQ-034 add (opcode 0, funct 100000) with mem_ready=1 SHALL produce states 0,1,2,4,0, with aluop=2 in EXEC and rf_we=1 only in WB.
REQ-035 lw with mem_ready low for 3 cycles in MEM SHALL hold MEM for 4 cycles with mem_re=1 and rf_we=0, followed by WB with mem_to_reg=1.
REQ-036 beq with zero=0 SHALL give pc_we=0 in EXEC; with zero=1 it SHALL give pc_we=1, pc_src=1; both SHALL return to FETCH after 3 cycles.
REQ-037 cmp (opcode 111111) SHALL give cmpflag=1 only in EXEC; movz with zero=0 SHALL give rf_we=0 in WB.
REQ-038 rst pulsed for 1 cycle during an sw MEM wait SHALL drop mem_we the same cycle and put state=0 after the edge.
REQ-039 Opcode 010000 SHALL give state=5 and trap=1 persisting with TRAP_EN defined, and a NOP return to FETCH after 2 cycles without it.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, ALU op
// classes, datapath select codes and the opcodes the main controller decodes.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_t;

   typedef enum logic [1:0] {
      SRCB_REG  = 2'd0,
      SRCB_FOUR = 2'd1,
      SRCB_IMM  = 2'd2
   } src_b_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_BRANCH = 2'd1,
      PCSRC_JUMP   = 2'd2
   } pc_src_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_CMP   = 6'b111111;

   localparam logic [5:0] FUNCT_MOVZ = 6'b001010;

   typedef struct packed {
      logic    pc_we;
      logic    ir_we;
      logic    mem_re;
      logic    mem_we;
      logic    rf_we;
      aluop_t  aluop;
      logic    cmpflag;
      logic    alu_src_a;
      src_b_t  alu_src_b;
      logic    reg_dst;
      logic    mem_to_reg;
      pc_src_t pc_src;
   } ctrl_t;

   function automatic logic is_defined_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_CMP: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/main_control_decode.sv
// Combinational output map of the main controller: current state plus
// instruction fields and ALU zero flag to the full control vector.
module main_control_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output ctrl_t      ctl
);

   always_comb begin
      ctl = '0;
      case (state)
         S_FETCH: begin
            // pc_we/ir_we here assume the fetch completes; the top gates them
            ctl.mem_re    = 1'b1;
            ctl.pc_we     = 1'b1;
            ctl.ir_we     = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            ctl.aluop     = ALUOP_ADD;
            ctl.pc_src    = PCSRC_ALU;
         end
         S_EXEC: begin
            case (opcode)
               OP_RTYPE: ctl.aluop = ALUOP_FUNCT;
               OP_CMP: begin
                  ctl.aluop   = ALUOP_FUNCT;
                  ctl.cmpflag = 1'b1;
               end
               OP_LW, OP_SW: begin
                  ctl.alu_src_b = SRCB_IMM;
                  ctl.aluop     = ALUOP_ADD;
               end
               OP_BEQ: begin
                  ctl.aluop  = ALUOP_SUB;
                  ctl.pc_src = PCSRC_BRANCH;
                  ctl.pc_we  = zero;
               end
               OP_J: begin
                  ctl.pc_src = PCSRC_JUMP;
                  ctl.pc_we  = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            ctl.mem_re = (opcode == OP_LW);
            ctl.mem_we = (opcode == OP_SW);
         end
         S_WB: begin
            ctl.rf_we = 1'b1;
            if (opcode == OP_LW) begin
               ctl.mem_to_reg = 1'b1;
            end else begin
               ctl.reg_dst = 1'b1;
            end
            if (opcode == OP_RTYPE && funct == FUNCT_MOVZ) begin
               ctl.rf_we = zero;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/main_control.sv
// Multicycle MIPS main controller: state register, next-state logic and reset
// gating of the enables. Define MAIN_CONTROL_TRAP_EN to trap undefined opcodes.
module main_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       ir_we,
   output logic       mem_re,
   output logic       mem_we,
   output logic       rf_we,
   output logic [1:0] aluop,
   output logic       cmpflag,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic [1:0] pc_src,
   output logic [2:0] state,
   output logic       trap
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctl;
   logic   fetch_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_defined_op(opcode)) begin
               state_d = S_EXEC;
            end else begin
`ifdef MAIN_CONTROL_TRAP_EN
               state_d = S_TRAP;
`else
               state_d = S_FETCH;
`endif
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_LW, OP_SW:     state_d = S_MEM;
               OP_RTYPE, OP_CMP: state_d = S_WB;
               default:          state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (opcode == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_WB:    state_d = S_FETCH;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   main_control_decode u_decode (
      .state  (state_q),
      .opcode (opcode),
      .funct  (funct),
      .zero   (zero),
      .ctl    (ctl)
   );

   // Reset gates the enables combinationally so they drop in the same cycle.
   assign fetch_hold = (state_q == S_FETCH) && !mem_ready;

   assign pc_we      = ctl.pc_we && !fetch_hold && !rst;
   assign ir_we      = ctl.ir_we && !fetch_hold && !rst;
   assign mem_re     = ctl.mem_re && !rst;
   assign mem_we     = ctl.mem_we && !rst;
   assign rf_we      = ctl.rf_we && !rst;
   assign aluop      = ctl.aluop;
   assign cmpflag    = ctl.cmpflag;
   assign alu_src_a  = ctl.alu_src_a;
   assign alu_src_b  = ctl.alu_src_b;
   assign reg_dst    = ctl.reg_dst;
   assign mem_to_reg = ctl.mem_to_reg;
   assign pc_src     = ctl.pc_src;
   assign state      = state_q;

`ifdef MAIN_CONTROL_TRAP_EN
   assign trap = (state_q == S_TRAP) && !rst;
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_main_control.sv
// Self-checking bench for main_control: a per-instruction cycle-trace model
// builds the expected output sequence, and one process compares every cycle.
module tb_main_control;

   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_CMP  = 6'b111111;
   localparam logic [5:0] T_MOVZ = 6'b001010;

   localparam int K_R = 0, K_CMP = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_BAD = 6;

   typedef struct packed {
      logic [2:0] st;
      logic       pc_we, ir_we, mem_re, mem_we, rf_we;
      logic [1:0] aluop;
      logic       cmpflag, alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_dst, mem_to_reg;
      logic [1:0] pc_src;
      logic       trap;
   } exp_t;

   typedef struct packed {
      logic       rst, mr, zero;
      logic [5:0] op, fn;
      exp_t       e;
   } rec_t;

   typedef rec_t rq_t[$];

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       pc_we, ir_we, mem_re, mem_we, rf_we, cmpflag, alu_src_a, reg_dst, mem_to_reg, trap;
   logic [1:0] aluop, alu_src_b, pc_src;
   logic [2:0] state;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic chk_en = 1'b0;
   exp_t exp_now;
   rq_t  sched;

   always #5 clk = ~clk;

   main_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re),
      .mem_we(mem_we), .rf_we(rf_we), .aluop(aluop), .cmpflag(cmpflag),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .pc_src(pc_src), .state(state), .trap(trap)
   );

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic legal(input logic [5:0] op);
      return op == T_R || op == T_LW || op == T_SW || op == T_BEQ || op == T_J || op == T_CMP;
   endfunction

   function automatic exp_t blank(input int st);
      exp_t e = '0;
      e.st = 3'(st);
      return e;
   endfunction

   function automatic exp_t with_rst(input exp_t e);
      exp_t r = e;
      r.pc_we = 0; r.ir_we = 0; r.mem_re = 0; r.mem_we = 0; r.rf_we = 0; r.trap = 0;
      return r;
   endfunction

   function automatic rec_t mk(input logic mr, input logic z, input exp_t e);
      rec_t r = '0;
      r.mr = mr; r.zero = z; r.e = e;
      return r;
   endfunction

   // Expected cycle-by-cycle trace of one instruction, from fetch to the next fetch.
   function automatic rq_t build(input int kind, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int fwait, input int mwait, input int rst_at);
      rq_t  q;
      exp_t e;
      int   ra = rst_at;
      for (int i = 0; i < fwait; i++) begin
         e = blank(0); e.mem_re = 1; e.alu_src_b = 2'd1;
         q.push_back(mk(1'b0, rnd(), e));
      end
      e = blank(0); e.mem_re = 1; e.alu_src_b = 2'd1; e.pc_we = 1; e.ir_we = 1;
      q.push_back(mk(1'b1, rnd(), e));
      q.push_back(mk(rnd(), rnd(), blank(1)));
      case (kind)
         K_R, K_CMP: begin
            e = blank(2); e.aluop = 2'd2; e.cmpflag = (kind == K_CMP);
            q.push_back(mk(rnd(), rnd(), e));
            e = blank(4); e.reg_dst = 1;
            e.rf_we = (kind == K_R && fn == T_MOVZ) ? z : 1'b1;
            q.push_back(mk(rnd(), z, e));
         end
         K_LW, K_SW: begin
            e = blank(2); e.alu_src_b = 2'd2;
            q.push_back(mk(rnd(), rnd(), e));
            e = blank(3); e.mem_re = (kind == K_LW); e.mem_we = (kind == K_SW);
            for (int i = 0; i < mwait; i++) q.push_back(mk(1'b0, rnd(), e));
            q.push_back(mk(1'b1, rnd(), e));
            if (kind == K_LW) begin
               e = blank(4); e.rf_we = 1; e.mem_to_reg = 1;
               q.push_back(mk(rnd(), rnd(), e));
            end
         end
         K_BEQ: begin
            e = blank(2); e.aluop = 2'd1; e.pc_src = 2'd1; e.pc_we = z;
            q.push_back(mk(rnd(), z, e));
         end
         K_J: begin
            e = blank(2); e.pc_src = 2'd2; e.pc_we = 1;
            q.push_back(mk(rnd(), rnd(), e));
         end
         default: begin
`ifdef MAIN_CONTROL_TRAP_EN
            e = blank(5); e.trap = 1;
            for (int i = 0; i <= mwait; i++) q.push_back(mk(rnd(), rnd(), e));
            if (ra < 0 || ra >= q.size()) ra = q.size() - 1;
`endif
         end
      endcase
      foreach (q[i]) begin
         q[i].op = op;
         q[i].fn = fn;
      end
      if (ra >= 0 && ra < q.size()) begin
         while (q.size() > ra + 1) void'(q.pop_back());
         q[ra].rst = 1'b1;
         q[ra].e   = with_rst(q[ra].e);
      end
      return q;
   endfunction

   function automatic logic [5:0] op_of(input int kind);
      logic [5:0] op;
      case (kind)
         K_R:   op = T_R;
         K_CMP: op = T_CMP;
         K_LW:  op = T_LW;
         K_SW:  op = T_SW;
         K_BEQ: op = T_BEQ;
         K_J:   op = T_J;
         default: begin
            op = 6'($urandom_range(0, 63));
            while (legal(op)) op = 6'($urandom_range(0, 63));
         end
      endcase
      return op;
   endfunction

   task automatic add(input rq_t q);
      foreach (q[i]) sched.push_back(q[i]);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   // Compare process: outputs settle after the posedge; check mid-cycle.
   initial begin
      exp_t act;
      int   cyc = 0;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (chk_en) begin
            act = {state, pc_we, ir_we, mem_re, mem_we, rf_we, aluop, cmpflag, alu_src_a,
                   alu_src_b, reg_dst, mem_to_reg, pc_src, trap};
            n_cmp++;
            if (act !== exp_now) begin
               n_bad++;
               $display("FAIL cycle%0d op=%b fn=%b rst=%b: got st=%0d vec=%h required st=%0d vec=%h",
                        cyc, opcode, funct, rst, act.st, act, exp_now.st, exp_now);
            end
         end
      end
   end

   initial begin
      rq_t  q;
      rec_t r;
      int   cnt;
      int   kind;
      logic [5:0] op, fn;

      rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;

      // Pin the trace model against hand-derived latencies.
      q = build(K_R, T_R, 6'b100000, 1'b0, 0, 0, -1);
      chk("model_add_len", q.size(), 4);
      chk("model_add_states", {q[0].e.st, q[1].e.st, q[2].e.st, q[3].e.st}, 12'o0124);
      q = build(K_LW, T_LW, 6'd0, 1'b0, 0, 3, -1);
      chk("model_lw_len", q.size(), 8);
      cnt = 0;
      foreach (q[i]) if (q[i].e.st == 3'd3 && q[i].e.mem_re) cnt++;
      chk("model_lw_mem_cycles", cnt, 4);
      chk("model_lw_wb_m2r", q[7].e.mem_to_reg, 1);
      q = build(K_SW, T_SW, 6'd0, 1'b0, 0, 0, -1);
      chk("model_sw_len", q.size(), 4);
      q = build(K_BEQ, T_BEQ, 6'd0, 1'b1, 0, 0, -1);
      chk("model_beq_len", q.size(), 3);
      chk("model_beq_taken", {q[2].e.pc_we, q[2].e.pc_src}, 3'b101);
      q = build(K_J, T_J, 6'd0, 1'b0, 0, 0, -1);
      chk("model_j_len", q.size(), 3);
      q = build(K_R, T_R, T_MOVZ, 1'b0, 0, 0, -1);
      chk("model_movz_rf_we", q[3].e.rf_we, 0);
      q = build(K_BAD, 6'b010000, 6'd0, 1'b0, 0, 3, -1);
`ifdef MAIN_CONTROL_TRAP_EN
      chk("model_bad_len", q.size(), 6);
`else
      chk("model_bad_len", q.size(), 2);
`endif

      // Directed scenarios.
      r = mk(1'b1, 1'b0, with_rst(build(K_J, T_J, 6'd0, 1'b0, 0, 0, -1)[0].e));
      r.rst = 1'b1;
      sched.push_back(r);
      add(build(K_R,   T_R,   6'b100000, rnd(), 0, 0, -1));
      add(build(K_LW,  T_LW,  6'd5,      rnd(), 0, 3, -1));
      add(build(K_BEQ, T_BEQ, 6'd0,      1'b0,  0, 0, -1));
      add(build(K_BEQ, T_BEQ, 6'd0,      1'b1,  0, 0, -1));
      add(build(K_CMP, T_CMP, 6'b101010, rnd(), 0, 0, -1));
      add(build(K_R,   T_R,   T_MOVZ,    1'b0,  0, 0, -1));
      add(build(K_R,   T_R,   T_MOVZ,    1'b1,  0, 0, -1));
      add(build(K_SW,  T_SW,  6'd0,      rnd(), 1, 2, 5));
      add(build(K_J,   T_J,   6'd0,      rnd(), 2, 0, -1));
      add(build(K_BAD, 6'b010000, 6'd0,  rnd(), 0, 3, -1));
      add(build(K_SW,  T_SW,  6'd0,      rnd(), 0, 0, -1));

      // Randomized instruction stream.
      for (int n = 0; n < 400; n++) begin
         kind = ($urandom_range(0, 9) == 0) ? K_BAD : int'($urandom_range(0, 5));
         op   = op_of(kind);
         fn   = ($urandom_range(0, 3) == 0) ? T_MOVZ : 6'($urandom_range(0, 63));
         add(build(kind, op, fn, rnd(),
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1));
      end

      foreach (sched[i]) begin
         @(negedge clk);
         rst       = sched[i].rst;
         mem_ready = sched[i].mr;
         zero      = sched[i].zero;
         opcode    = sched[i].op;
         funct     = sched[i].fn;
         exp_now   = sched[i].e;
         chk_en    = 1'b1;
      end
      @(negedge clk);
      chk_en = 1'b0;
      #5;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
